// File: rtl/run_ctrl.sv
// run_ctrl: run-control and watchdog block for the top-level bench.
// Watches NCH commit/halt channels and NERR error sources. It also keeps a
// global cycle timeout and a no-commit (deadlock) watchdog. It raises one
// sticky finish with a cause code and the index of the event that caused it.
module run_ctrl #(
    parameter int NCH            = 8,
    parameter int NERR           = 3,
    parameter int TO_W           = 32,
    parameter int TIMEOUT_CYCLES = 1000000000,
    parameter int STALL_LIMIT    = 100000,
    parameter int DRAIN_CYCLES   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  commit_valid,
    input  logic [NCH-1:0]  halt,
    input  logic [NERR-1:0] err,
    output logic            finish,
    output logic [2:0]      finish_code,
    output logic [7:0]      evt_idx,
    output logic [63:0]     cycle_count,
    output logic [63:0]     commit_count
);

    localparam int CNT_W = $clog2(NCH + 1);

    localparam logic [TO_W-1:0] TO_INIT    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]     STALL_LAST = 32'(STALL_LIMIT - 1);
    localparam logic [31:0]     DRAIN_LOAD = 32'(DRAIN_CYCLES - 1);

    localparam logic [2:0] CODE_HALT    = 3'd1;
    localparam logic [2:0] CODE_ERROR   = 3'd2;
    localparam logic [2:0] CODE_TIMEOUT = 3'd3;
    localparam logic [2:0] CODE_STALL   = 3'd4;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // The channel and source indices are reported in 8 bits, so wider
    // configurations cannot be represented.
    if (NCH < 1 || NCH > 256 || NERR < 1 || NERR > 256) begin : g_param_check
        $error("run_ctrl: NCH and NERR must lie in 1..256");
    end

    state_t          state;
    state_t          state_next;
    logic [TO_W-1:0] to_cnt;
    logic [31:0]     stall_cnt;
    logic [31:0]     drain_cnt;
    logic [2:0]      code_q;
    logic [2:0]      code_next;
    logic [7:0]      idx_q;
    logic [7:0]      idx_next;

    // Index of the lowest set halt bit. The scan runs downwards so that
    // the lowest set bit is the last one written.
    function automatic logic [7:0] lowest_halt(input logic [NCH-1:0] v);
        logic [7:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 8'(i);
            end
        end
        return idx;
    endfunction

    // Index of the lowest set error bit.
    function automatic logic [7:0] lowest_err(input logic [NERR-1:0] v);
        logic [7:0] idx;
        idx = '0;
        for (int i = NERR - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 8'(i);
            end
        end
        return idx;
    endfunction

    // Number of channels that commit in this cycle.
    function automatic logic [CNT_W-1:0] popcount(input logic [NCH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NCH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // State register: reset always returns to RUN, wherever the block was.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and latched cause. In RUN the priority is halt, then
    // error, then timeout, then stall.
    always_comb begin
        state_next = state;
        code_next  = code_q;
        idx_next   = idx_q;
        case (state)
            S_RUN: begin
                if (halt != '0) begin
                    state_next = S_DONE;
                    code_next  = CODE_HALT;
                    idx_next   = lowest_halt(halt);
                end else if (err != '0) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_DRAIN;
                    end
                    code_next = CODE_ERROR;
                    idx_next  = lowest_err(err);
                end else if (to_cnt == '0) begin
                    state_next = S_DONE;
                    code_next  = CODE_TIMEOUT;
                    idx_next   = '0;
                end else if (STALL_LIMIT != 0 && stall_cnt == STALL_LAST &&
                             commit_valid == '0) begin
                    state_next = S_DONE;
                    code_next  = CODE_STALL;
                    idx_next   = '0;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    // Counters and cause registers. They update in RUN and DRAIN and are
    // frozen in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt       <= TO_INIT;
            stall_cnt    <= '0;
            drain_cnt    <= '0;
            code_q       <= '0;
            idx_q        <= '0;
            cycle_count  <= '0;
            commit_count <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    to_cnt       <= (to_cnt == '0) ? '0 : to_cnt - 1'b1;
                    stall_cnt    <= (commit_valid != '0) ? '0 : stall_cnt + 32'd1;
                    commit_count <= commit_count + 64'(popcount(commit_valid));
                    cycle_count  <= cycle_count + 64'd1;
                    code_q       <= code_next;
                    idx_q        <= idx_next;
                    if (state_next == S_DRAIN) begin
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                S_DRAIN: begin
                    commit_count <= commit_count + 64'(popcount(commit_valid));
                    cycle_count  <= cycle_count + 64'd1;
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - 32'd1;
                    end
                end
                S_DONE: begin
                    cycle_count <= cycle_count;
                end
                default: begin
                    cycle_count <= cycle_count;
                end
            endcase
        end
    end

    // Outputs: finish is decoded from the state, and the cause comes from the
    // registers.
    always_comb begin
        finish      = (state == S_DONE);
        finish_code = code_q;
        evt_idx     = idx_q;
    end

    // Unknown halt or error inputs while running mean the bench is broken.
    a_no_x_events : assert property (@(posedge clk) disable iff (rst)
        (state == S_RUN) |-> !$isunknown({halt, err}));

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed and randomized checks of run_ctrl.
// Instance A runs with a short timeout, a stall limit and a drain phase.
// Instance B runs with a tiny timeout, no stall check and no drain phase.
module tb_run_ctrl;

    localparam int NCH       = 8;
    localparam int NERR      = 3;
    localparam int A_TIMEOUT = 300;
    localparam int A_STALL   = 16;
    localparam int A_DRAIN   = 5;
    localparam int B_TIMEOUT = 50;

    logic            clk;
    logic            rst_a;
    logic            rst_b;
    logic [NCH-1:0]  commit_valid;
    logic [NCH-1:0]  halt;
    logic [NERR-1:0] err;

    logic            finish_a, finish_b;
    logic [2:0]      code_a, code_b;
    logic [7:0]      idx_a, idx_b;
    logic [63:0]     cyc_a, cyc_b;
    logic [63:0]     cmt_a, cmt_b;

    int checks = 0;
    int errors = 0;

    // Reference model of instance A, kept in absolute cycle numbers.
    // The phase is 0 for running, 1 for draining and 2 for finished.
    int     m_phase;
    int     m_code;
    int     m_idx;
    int     m_streak;
    longint m_cycles;
    longint m_commits;
    longint m_finish_at;

    int              density;
    int              evt_rate;
    logic [NCH-1:0]  r_cv;
    logic [NCH-1:0]  r_h;
    logic [NERR-1:0] r_e;

    run_ctrl #(
        .NCH(NCH), .NERR(NERR), .TO_W(32), .TIMEOUT_CYCLES(A_TIMEOUT),
        .STALL_LIMIT(A_STALL), .DRAIN_CYCLES(A_DRAIN)
    ) dut_a (
        .clk(clk), .rst(rst_a), .commit_valid(commit_valid), .halt(halt), .err(err),
        .finish(finish_a), .finish_code(code_a), .evt_idx(idx_a),
        .cycle_count(cyc_a), .commit_count(cmt_a)
    );

    run_ctrl #(
        .NCH(NCH), .NERR(NERR), .TO_W(32), .TIMEOUT_CYCLES(B_TIMEOUT),
        .STALL_LIMIT(0), .DRAIN_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .commit_valid(commit_valid), .halt(halt), .err(err),
        .finish(finish_b), .finish_code(code_b), .evt_idx(idx_b),
        .cycle_count(cyc_b), .commit_count(cmt_b)
    );

    // Free-running clock. Inputs change and outputs are sampled on the
    // falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [NCH-1:0] cv, input logic [NCH-1:0] h,
                                 input logic [NERR-1:0] e);
        commit_valid = cv;
        halt         = h;
        err          = e;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkSet(input string tag,
                            input logic ofin, input logic [2:0] ocode, input logic [7:0] oidx,
                            input logic [63:0] ocyc, input logic [63:0] ocmt,
                            input logic efin, input logic [2:0] ecode, input logic [7:0] eidx,
                            input logic [63:0] ecyc, input logic [63:0] ecmt);
        checkOutput({tag, ".finish"}, 64'(ofin), 64'(efin));
        checkOutput({tag, ".code"}, 64'(ocode), 64'(ecode));
        checkOutput({tag, ".evt_idx"}, 64'(oidx), 64'(eidx));
        checkOutput({tag, ".cycles"}, ocyc, ecyc);
        checkOutput({tag, ".commits"}, ocmt, ecmt);
    endtask

    task automatic checkA(input string tag, input logic fin, input logic [2:0] code,
                          input logic [7:0] idx, input logic [63:0] cyc, input logic [63:0] cmt);
        checkSet(tag, finish_a, code_a, idx_a, cyc_a, cmt_a, fin, code, idx, cyc, cmt);
    endtask

    task automatic checkB(input string tag, input logic fin, input logic [2:0] code,
                          input logic [7:0] idx, input logic [63:0] cyc, input logic [63:0] cmt);
        checkSet(tag, finish_b, code_b, idx_b, cyc_b, cmt_b, fin, code, idx, cyc, cmt);
    endtask

    // After this task returns, the next rising edge is cycle 0 of instance A.
    // Instance B is held in reset.
    task automatic resetA();
        rst_a = 1'b1;
        rst_b = 1'b1;
        applyStimulus('0, '0, '0);
        applyStimulus('0, '0, '0);
        rst_a = 1'b0;
    endtask

    task automatic resetB();
        rst_a = 1'b1;
        rst_b = 1'b1;
        applyStimulus('0, '0, '0);
        applyStimulus('0, '0, '0);
        rst_b = 1'b0;
    endtask

    function automatic int lowestSet(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic modelReset();
        m_phase     = 0;
        m_code      = 0;
        m_idx       = 0;
        m_streak    = 0;
        m_cycles    = 0;
        m_commits   = 0;
        m_finish_at = 0;
    endtask

    // Advances the model by one cycle with the inputs seen in that cycle.
    // n is the index of the cycle within the run.
    task automatic modelStep(input logic [NCH-1:0] cv, input logic [NCH-1:0] h,
                             input logic [NERR-1:0] e);
        longint n;
        n = m_cycles;
        if (m_phase == 2) return;
        m_commits += $countones(cv);
        m_cycles  += 1;
        if (m_phase == 1) begin
            if (n + 1 == m_finish_at) m_phase = 2;
            return;
        end
        m_streak = (cv != '0) ? 0 : m_streak + 1;
        if (h != '0) begin
            m_phase = 2;
            m_code  = 1;
            m_idx   = lowestSet(h);
        end else if (e != '0) begin
            m_code      = 2;
            m_idx       = lowestSet(NCH'(e));
            m_phase     = 1;
            m_finish_at = n + A_DRAIN + 1;
        end else if (n == A_TIMEOUT) begin
            m_phase = 2;
            m_code  = 3;
            m_idx   = 0;
        end else if (m_streak == A_STALL) begin
            m_phase = 2;
            m_code  = 4;
            m_idx   = 0;
        end
    endtask

    initial begin
        rst_a        = 1'b1;
        rst_b        = 1'b1;
        commit_valid = '0;
        halt         = '0;
        err          = '0;

        // Reset state, then a halt on channel 5 in cycle 10 with five commits per cycle.
        resetA();
        checkA("reset", 1'b0, 3'd0, 8'd0, 64'd0, 64'd0);
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) checkOutput("halt.pre", 64'(finish_a), 64'd0);
            applyStimulus(8'hB5, (c == 10) ? 8'h20 : 8'h00, 3'b000);
        end
        checkA("halt", 1'b1, 3'd1, 8'd5, 64'd11, 64'd55);
        for (int c = 0; c < 3; c++) applyStimulus(8'hFF, 8'h01, 3'b111);
        checkA("halt.hold", 1'b1, 3'd1, 8'd5, 64'd11, 64'd55);

        // Reset while in DONE.
        rst_a = 1'b1;
        applyStimulus(8'hFF, 8'hFF, 3'b111);
        checkA("rst_done", 1'b0, 3'd0, 8'd0, 64'd0, 64'd0);
        rst_a = 1'b0;

        // Halt and error in the same cycle: halt wins, with no drain phase.
        resetA();
        for (int c = 0; c < 5; c++) applyStimulus(8'h01, 8'h00, 3'b000);
        applyStimulus(8'h01, 8'h24, 3'b001);
        checkA("halt_err", 1'b1, 3'd1, 8'd2, 64'd6, 64'd6);

        // Error in cycle 20. Drain covers cycles 21-25. Later halts and errors are ignored.
        resetA();
        for (int c = 0; c <= 25; c++) begin
            checkOutput("drain.busy", 64'(finish_a), 64'd0);
            applyStimulus(8'h03, (c == 22) ? 8'h01 : 8'h00,
                          (c == 20) ? 3'b110 : ((c == 23) ? 3'b001 : 3'b000));
        end
        checkA("drain", 1'b1, 3'd2, 8'd1, 64'd26, 64'd52);

        // Reset in the middle of a drain, then a fresh run that ends on a halt.
        resetA();
        applyStimulus(8'h01, 8'h00, 3'b100);
        applyStimulus(8'h01, 8'h00, 3'b000);
        rst_a = 1'b1;
        applyStimulus(8'h01, 8'h00, 3'b000);
        checkA("rst_drain", 1'b0, 3'd0, 8'd0, 64'd0, 64'd0);
        rst_a = 1'b0;
        for (int c = 0; c <= 3; c++) applyStimulus(8'h01, (c == 3) ? 8'h80 : 8'h00, 3'b000);
        checkA("after_rst", 1'b1, 3'd1, 8'd7, 64'd4, 64'd4);

        // Stall: the last commit is in cycle 3, so finish comes at cycle 20.
        resetA();
        for (int c = 0; c <= 21; c++) begin
            checkOutput("stall1.finish", 64'(finish_a), 64'(c >= 20));
            applyStimulus((c <= 3) ? 8'h01 : 8'h00, 8'h00, 3'b000);
        end
        checkA("stall1", 1'b1, 3'd4, 8'd0, 64'd20, 64'd4);

        // Stall again, with one extra commit in cycle 10, so finish comes at cycle 27.
        resetA();
        for (int c = 0; c <= 28; c++) begin
            checkOutput("stall2.finish", 64'(finish_a), 64'(c >= 27));
            applyStimulus((c <= 3 || c == 10) ? 8'h01 : 8'h00, 8'h00, 3'b000);
        end
        checkA("stall2", 1'b1, 3'd4, 8'd0, 64'd27, 64'd5);

        // Timeout of 50 with the stall check disabled, so finish comes at cycle 51.
        resetB();
        checkB("b.reset", 1'b0, 3'd0, 8'd0, 64'd0, 64'd0);
        for (int c = 0; c <= 52; c++) begin
            checkOutput("timeout.finish", 64'(finish_b), 64'(c >= 51));
            applyStimulus(8'h00, 8'h00, 3'b000);
        end
        checkB("timeout", 1'b1, 3'd3, 8'd0, 64'd51, 64'd0);

        // With no drain phase, an error finishes the run on the next cycle.
        resetB();
        for (int c = 0; c < 7; c++) applyStimulus(8'h0F, 8'h00, 3'b000);
        applyStimulus(8'h0F, 8'h00, 3'b100);
        checkB("err_nodrain", 1'b1, 3'd2, 8'd2, 64'd8, 64'd32);

        // Randomized episodes on instance A, checked against the reference model.
        for (int ep = 0; ep < 12; ep++) begin
            density  = (ep == 0) ? 4 : int'($urandom_range(0, 4));
            evt_rate = (ep % 3 == 0) ? 0 : int'($urandom_range(40, 200));
            resetA();
            modelReset();
            for (int c = 0; c < A_TIMEOUT + 20; c++) begin
                checkOutput("rnd.finish", 64'(finish_a), 64'(m_phase == 2));
                checkOutput("rnd.commits", cmt_a, 64'(m_commits));
                r_cv = (int'($urandom_range(0, 3)) < density) ? NCH'($urandom) : '0;
                r_h  = '0;
                r_e  = '0;
                if (evt_rate != 0 && $urandom_range(1, evt_rate) == 1)
                    r_h = NCH'($urandom) & NCH'($urandom);
                if (evt_rate != 0 && $urandom_range(1, evt_rate) == 1)
                    r_e = NERR'($urandom);
                modelStep(r_cv, r_h, r_e);
                applyStimulus(r_cv, r_h, r_e);
            end
            checkA("rnd.end", m_phase == 2, 3'(m_code), 8'(m_idx),
                   64'(m_cycles), 64'(m_commits));
        end

        rst_a = 1'b1;
        rst_b = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
